// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: fetch, decode, execute, memory and writeback sequencing.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal opcodes trap into HALT and set a sticky illegal flag.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             memReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCWrite,
    output logic             PCWriteIfZero,
    output logic             PCWriteIfNonZero,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instrCount,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
`ifdef ILLEGAL_OP_TRAP_EN
    logic             r_illegal;
`endif

    // NOTE: state is updated with non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RST;
            r_count   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_RST:   r_state <= S_FETCH;
                S_FETCH: if (memReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW:   r_state <= S_MEMADR;
                        OP_RTYPE:       r_state <= S_EXEC;
                        OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                        OP_J:           r_state <= S_JUMP;
                        OP_ADDI:        r_state <= S_ADDIEX;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
`else
                            r_state   <= S_FETCH;
                            r_count   <= r_count + CNT_ONE;
`endif
                        end
                    endcase
                end
                S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (memReady) r_state <= S_MEMWB;
                S_MEMWR: begin
                    if (memReady) begin
                        r_state <= S_FETCH;
                        r_count <= r_count + CNT_ONE;
                    end
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + CNT_ONE;
                end
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_RST;
            endcase
        end
    end

    // Moore decode from state; only the FETCH PC/IR strobes look at memReady.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        IorD             = 1'b0;
        MemRead          = 1'b0;
        MemWrite         = 1'b0;
        IRWrite          = 1'b0;
        RegDst           = 1'b0;
        MemtoReg         = 1'b0;
        RegWrite         = 1'b0;
        ALUSrcA          = 1'b0;
        ALUSrcB          = 2'b00;
        ALUOp            = 2'b00;
        PCSource         = 2'b00;
        PCWrite          = 1'b0;
        PCWriteIfZero    = 1'b0;
        PCWriteIfNonZero = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead          = 1'b1;
                ALUSrcB          = 2'b01;
                IRWrite          = memReady;
                PCWrite          = memReady;
                PCWriteIfZero    = memReady;
                PCWriteIfNonZero = memReady;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA          = 1'b1;
                ALUOp            = 2'b01;
                PCSource         = 2'b01;
                PCWrite          = 1'b1;
                PCWriteIfZero    = (op == OP_BEQ);
                PCWriteIfNonZero = (op == OP_BNE);
            end
            S_JUMP: begin
                PCSource         = 2'b10;
                PCWrite          = 1'b1;
                PCWriteIfZero    = 1'b1;
                PCWriteIfNonZero = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = r_state;
    assign instrCount = r_count;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal    = r_illegal;
`else
    assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected records are queued as stimulus
// is driven and compared against the DUT once its outputs settle.
module tb_multicycle_control;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                           S_ADDIWB = 4'd12, S_HALT = 4'd13;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
        logic       pcwrite, pcz, pcnz;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctrl_t       ctrl;
        logic [31:0] cnt;
        logic        ill;
    } obs_t;

    typedef struct packed {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
    } step_t;

    logic        clk, reset, memReady;
    logic [5:0]  op;
    logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        PCWrite, PCWriteIfZero, PCWriteIfNonZero, illegal;
    logic [3:0]  state;
    logic [31:0] instrCount;

    int          n_cmp = 0;
    int          n_mis = 0;
    obs_t        sb[$];
    logic [31:0] exp_cnt = '0;
    logic        exp_ill = 1'b0;
    logic [3:0]  prev_st = S_RST;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .memReady(memReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
        .PCWriteIfZero(PCWriteIfZero), .PCWriteIfNonZero(PCWriteIfNonZero),
        .state(state), .instrCount(instrCount), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control outputs required in each state, written from the state table.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] o, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; c.pcz = mr; c.pcnz = mr; end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_MEMRD:  begin c.memread = 1; c.iord = 1; end
            S_MEMWB:  begin c.regwrite = 1; c.memtoreg = 1; end
            S_MEMWR:  begin c.memwrite = 1; c.iord = 1; end
            S_EXEC:   begin c.alusrca = 1; c.aluop = 2'b10; end
            S_ALUWB:  begin c.regwrite = 1; c.regdst = 1; end
            S_ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_ADDIWB: c.regwrite = 1;
            S_BRANCH: begin
                c.alusrca = 1; c.aluop = 2'b01; c.pcsource = 2'b01; c.pcwrite = 1;
                c.pcz = (o == OP_BEQ); c.pcnz = (o == OP_BNE);
            end
            S_JUMP:   begin c.pcsource = 2'b10; c.pcwrite = 1; c.pcz = 1; c.pcnz = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.st   = state;
        s.ctrl = '{IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteIfZero, PCWriteIfNonZero};
        s.cnt  = instrCount;
        s.ill  = illegal;
        return s;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic drive(input step_t s);
        op       = s.op;
        memReady = s.mr;
        if (s.st == S_FETCH && prev_st != S_RST && prev_st != S_FETCH) exp_cnt = exp_cnt + 1;
        if (s.st == S_HALT) exp_ill = 1'b1;
        prev_st = s.st;
        sb.push_back('{s.st, exp_ctrl(s.st, s.op, s.mr), exp_cnt, exp_ill});
    endtask

    task automatic model_reset();
        exp_cnt = '0;
        exp_ill = 1'b0;
        prev_st = S_RST;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        @(negedge clk);
        drive('{OP_R, 1'b0, S_RST});
        #1;
        got = sample(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL reset: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                     got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
        end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        obs_t  got, exp;
        step_t seq [0:4] = '{'{OP_R, 1'b1, S_FETCH}, '{OP_R, 1'b1, S_DECODE}, '{OP_R, 1'b1, S_EXEC},
                             '{OP_R, 1'b1, S_ALUWB}, '{OP_R, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL rtype[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    task automatic test_lw_wait();
        obs_t  got, exp;
        step_t seq [0:8] = '{'{OP_LW, 1'b1, S_FETCH}, '{OP_LW, 1'b1, S_DECODE}, '{OP_LW, 1'b1, S_MEMADR},
                             '{OP_LW, 1'b0, S_MEMRD}, '{OP_LW, 1'b0, S_MEMRD}, '{OP_LW, 1'b0, S_MEMRD},
                             '{OP_LW, 1'b1, S_MEMRD}, '{OP_LW, 1'b1, S_MEMWB}, '{OP_LW, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL lw[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    task automatic test_branch();
        obs_t  got, exp;
        step_t seq [0:6] = '{'{OP_BEQ, 1'b1, S_FETCH}, '{OP_BEQ, 1'b1, S_DECODE}, '{OP_BEQ, 1'b1, S_BRANCH},
                             '{OP_BNE, 1'b1, S_FETCH}, '{OP_BNE, 1'b1, S_DECODE}, '{OP_BNE, 1'b1, S_BRANCH},
                             '{OP_BNE, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL branch[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    task automatic test_jump();
        obs_t  got, exp;
        step_t seq [0:3] = '{'{OP_J, 1'b1, S_FETCH}, '{OP_J, 1'b1, S_DECODE}, '{OP_J, 1'b1, S_JUMP},
                             '{OP_J, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL jump[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    task automatic test_addi();
        obs_t  got, exp;
        step_t seq [0:4] = '{'{OP_ADDI, 1'b1, S_FETCH}, '{OP_ADDI, 1'b1, S_DECODE}, '{OP_ADDI, 1'b1, S_ADDIEX},
                             '{OP_ADDI, 1'b1, S_ADDIWB}, '{OP_ADDI, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL addi[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    task automatic test_sw();
        obs_t  got, exp;
        step_t seq [0:5] = '{'{OP_SW, 1'b1, S_FETCH}, '{OP_SW, 1'b1, S_DECODE}, '{OP_SW, 1'b1, S_MEMADR},
                             '{OP_SW, 1'b0, S_MEMWR}, '{OP_SW, 1'b1, S_MEMWR}, '{OP_SW, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL sw[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    // Reset lands mid-cycle while a store waits on memory; strobes must drop without a clock edge.
    task automatic test_reset_midwrite();
        obs_t  got, exp;
        step_t seq [0:7] = '{'{OP_SW, 1'b1, S_FETCH}, '{OP_SW, 1'b1, S_DECODE}, '{OP_SW, 1'b1, S_MEMADR},
                             '{OP_SW, 1'b0, S_MEMWR}, '{OP_SW, 1'b0, S_MEMWR}, '{OP_SW, 1'b0, S_RST},
                             '{OP_SW, 1'b0, S_RST}, '{OP_SW, 1'b0, S_FETCH}};
        foreach (seq[i]) begin
            if (i == 5) begin
                reset = 1'b1;
                model_reset();
            end else begin
                @(negedge clk);
            end
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL rst_midwr[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
            if (i == 6) reset = 1'b0;
        end
    endtask

    task automatic test_illegal();
        obs_t  got, exp;
`ifdef ILLEGAL_OP_TRAP_EN
        step_t seq [0:11];
        seq[0] = '{OP_BAD, 1'b1, S_FETCH};
        seq[1] = '{OP_BAD, 1'b1, S_DECODE};
        for (int k = 2; k < 12; k++) seq[k] = '{OP_R, 1'b1, S_HALT};
`else
        step_t seq [0:2] = '{'{OP_BAD, 1'b1, S_FETCH}, '{OP_BAD, 1'b1, S_DECODE}, '{OP_BAD, 1'b0, S_FETCH}};
`endif
        foreach (seq[i]) begin
            @(negedge clk);
            drive(seq[i]);
            #1;
            got = sample(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_mis++;
                $display("FAIL illegal[%0d]: got st=%0d ctrl=%05h cnt=%0d ill=%b, expected st=%0d ctrl=%05h cnt=%0d ill=%b",
                         i, got.st, got.ctrl, got.cnt, got.ill, exp.st, exp.ctrl, exp.cnt, exp.ill);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        op       = OP_R;
        memReady = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jump();
        test_addi();
        test_sw();
        test_reset_midwrite();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
